// File: rtl/load_ext_pkg.sv
// Shared definitions for the load extend unit.
//   size_e       : access size encoding carried on in_size
//   fifo_entry_t : one buffered result (data sized for the widest build, plus error flag)
//   FIFO_DEPTH   : number of result slots between request and response sides
package load_ext_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } size_e;

   localparam int MAX_DATA_W = 64;
   localparam int FIFO_DEPTH = 2;

   // Data is held at the maximum width; narrower builds use the low DATA_W bits.
   typedef struct packed {
      logic [MAX_DATA_W-1:0] data;
      logic                  err;
   } fifo_entry_t;

endpackage

// File: rtl/load_extend_unit_if.sv
// Request/response bus of the load extend unit.
//   request side : in_valid, in_ready, in_data, in_off, in_size, in_zext
//   response side: out_valid, out_ready, out_data, out_err
//   master modport drives requests and consumes results; slave is the unit.
interface load_extend_unit_if #(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W/8)
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [OFF_W-1:0]  in_off;
   logic [1:0]        in_size;
   logic              in_zext;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err;

   modport master (
      output in_valid, in_data, in_off, in_size, in_zext, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, in_off, in_size, in_zext, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/load_extend_unit_ext_lane.sv
// ext_lane: combinational field extraction and zero/sign extension.
//   data   : raw memory word
//   off    : byte offset of the field within data
//   size   : field size (byte/half/word/double)
//   zext   : 1 = zero-extend, 0 = sign-extend
//   result : extended field (0 when err)
//   err    : field wider than the data path, or misaligned when
//            LOAD_EXT_ALIGN_CHECK_EN is defined
// Without LOAD_EXT_ALIGN_CHECK_EN, misaligned fields are extracted as-is and
// bits past the top of data read as 0.
module ext_lane
   import load_ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] data,
   input  logic [OFF_W-1:0]  off,
   input  logic [1:0]        size,
   input  logic              zext,
   output logic [DATA_W-1:0] result,
   output logic              err
);

   logic [DATA_W-1:0] shifted;
   logic [2:0]        off_ext;
   int                fw;
   logic              sign;
   logic              misalign;

   always_comb begin
      // logical shift: bits above the word fill with 0
      shifted  = data >> {off, 3'b000};
      off_ext  = 3'(off);
      fw       = int'(7'd8 << size);
      sign     = 1'b0;
      misalign = 1'b0;
      result   = '0;

      for (int i = 0; i < DATA_W; i++)
         if (i == fw - 1) sign = shifted[i];

`ifdef LOAD_EXT_ALIGN_CHECK_EN
      case (size_e'(size))
         SZ_BYTE:  misalign = 1'b0;
         SZ_HALF:  misalign = off_ext[0];
         SZ_WORD:  misalign = |off_ext[1:0];
         default:  misalign = |off_ext;
      endcase
`endif

      err = (fw > DATA_W) || misalign;

      // full-width field leaves no upper bits, so it passes straight through
      for (int i = 0; i < DATA_W; i++)
         result[i] = (i < fw) ? shifted[i] : (!zext & sign);

      if (err) result = '0;
   end

endmodule

// File: rtl/load_extend_unit.sv
// load_extend_unit: accepts load requests, extracts/extends the addressed
// field via ext_lane, and buffers results in a 2-entry FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of load_extend_unit_if (valid/ready on both sides)
// in_ready and out_valid depend only on the registered count, so there is no
// combinational path from out_ready to in_ready. A full FIFO cannot accept in
// the same cycle it retires.
// Build option: LOAD_EXT_ALIGN_CHECK_EN (misaligned requests flagged as errors).
module load_extend_unit
   import load_ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input logic               clk,
   input logic               rst,
   load_extend_unit_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   fifo_entry_t       mem [FIFO_DEPTH];
   fifo_entry_t       head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [1:0]        count;
   logic [DATA_W-1:0] lane_result;
   logic              lane_err;
   logic              accept;
   logic              retire;

   ext_lane #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_lane (
      .data   (bus.in_data),
      .off    (bus.in_off),
      .size   (bus.in_size),
      .zext   (bus.in_zext),
      .result (lane_result),
      .err    (lane_err)
   );

   assign bus.in_ready  = (count != 2'(FIFO_DEPTH));
   assign bus.out_valid = (count != 2'd0);
   assign accept        = bus.in_valid && bus.in_ready;
   assign retire        = bus.out_valid && bus.out_ready;

   assign head         = mem[rd_ptr];
   assign bus.out_data = bus.out_valid ? head.data[DATA_W-1:0] : '0;
   assign bus.out_err  = bus.out_valid & head.err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= '{data: MAX_DATA_W'(lane_result), err: lane_err};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (retire) rd_ptr <= rd_ptr + 1'b1;
         case ({accept, retire})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/load_extend_unit.md
LOAD_EXTEND_UNIT -- requirements
Module: load_extend_unit

Interface
REQ-001 Parameter DATA_W, default 32, data path width in bits; legal values 32 and 64.
REQ-002 Parameter OFF_W, default $clog2(DATA_W/8), byte-offset width; derived, not overridden.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  unit can accept a request this cycle.
REQ-007 in_data  in  DATA_W  raw memory word.
REQ-008 in_off  in  OFF_W  byte offset of the access within in_data.
REQ-009 in_size  in  2  access size: 00 byte, 01 half, 10 word (4 B), 11 double (8 B).
REQ-010 in_zext  in  1  1 = zero-extend, 0 = sign-extend.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts the result this cycle.
REQ-013 out_data  out  DATA_W  extracted and extended result.
REQ-014 out_err  out  1  request was illegal; see REQ-022.

Function
REQ-015 A request is accepted on a clock edge with in_valid && in_ready; a result is retired on a clock edge with out_valid && out_ready.
REQ-016 Buffer: 2-entry FIFO with count 0..2; in_ready = (count != 2), registered-state only, with no combinational path from out_ready.
REQ-017 Latency: a request accepted in cycle N with the FIFO empty gives out_valid = 1 in cycle N+1.
REQ-018 Extraction: field = in_data[8*in_off +: 8*2^in_size]; field width in bits = 8 << in_size.
REQ-019 Extension: upper bits = 0 when in_zext = 1; otherwise every upper bit equals the field MSB; size equal to DATA_W passes through unchanged.
REQ-020 Simultaneous accept and retire at count 1: count stays 1, the new entry becomes the head in the next cycle, and no data is lost or duplicated.
REQ-021 Count 2 with retire: count goes to 1 and in_ready = 1 in the following cycle; an accept is impossible in the same cycle.
REQ-022 Illegal request: (8 << in_size) > DATA_W. Result out_data = 0, out_err = 1, and the request occupies one FIFO slot like any other.
REQ-023 A retire with count 0, or an accept with count 2, cannot occur; the FIFO state is unchanged.
REQ-024 out_data and out_err are driven from the head entry and stay stable while out_valid && !out_ready.

Reset
REQ-025 While rst = 1: count = 0, out_valid = 0, in_ready = 1, out_data = 0, out_err = 0, and read/write pointers = 0.
REQ-026 Reset asserted mid-operation discards all buffered entries at once; no result is retired after reset releases.

Configuration
REQ-027 Macro LOAD_EXT_ALIGN_CHECK_EN.
- When defined: a request with in_off not a multiple of (1 << in_size) is also illegal, with the same response as REQ-022.
- When undefined: misaligned fields are extracted per REQ-018, and bits beyond DATA_W-1 read as 0.

Structure
REQ-028 Shared package load_ext_pkg holds:
- the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
- the FIFO entry struct {data, err};
- the constant FIFO_DEPTH = 2.
REQ-029 The combinational extract/extend logic sits in sub-module ext_lane (inputs data, off, size, zext; outputs result, err). load_extend_unit holds only the FIFO and handshake logic.

Verification
REQ-030 DATA_W=32, in_data=0x80F1_7F22, off=2, size=00, zext=0 -> out_data=0xFFFF_FFF1 one cycle later; the same request with zext=1 -> 0x0000_00F1.
REQ-031 DATA_W=32, in_data=0x1234_8001, off=0, size=01, zext=0 -> out_data=0xFFFF_8001; size=10 -> 0x1234_8001 unchanged.
REQ-032 DATA_W=32, size=11 -> out_data=0, out_err=1.
REQ-033 DATA_W=64, in_data=0x8000_0000_0000_0000, off=4, size=10, zext=0 -> out_data=0xFFFF_FFFF_8000_0000.
REQ-034 Back-pressure: hold out_ready=0 and push 3 requests.
- in_ready drops after 2 accepts and the third request waits.
- Release out_ready: results emerge in order, and the third request is accepted the cycle after the first retire.
REQ-035 Assert rst with count=2 -> out_valid=0 and in_ready=1 immediately; no stale result appears after release.
REQ-036 With LOAD_EXT_ALIGN_CHECK_EN defined: off=1, size=01 -> out_err=1. Undefined: extracted half = in_data[23:8].
